riscv_mem_arbiter: RTL and testbench



---
 rtl/riscv_arb_pkg.sv | 5 +
 rtl/riscv_arb_prio.sv | 32 +++
 rtl/riscv_mem_arbiter.sv | 60 ++++++
 tb/tb_riscv_mem_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_arb_pkg.sv
// riscv_arb_pkg: shared types and defaults for the instruction/data memory arbiter.
package riscv_arb_pkg;
   typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} owner_t;
   localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/riscv_arb_prio.sv
// riscv_arb_prio: picks the fetch/data winner each cycle; fixed data priority with a
// fetch starvation guard, or round-robin on conflicts when RISCV_ARB_RR_EN is defined.
module riscv_arb_prio
   import riscv_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_req,
   input  logic d_req,
   output logic i_win,
   output logic d_win
);
`ifdef RISCV_ARB_RR_EN
   // last_d: data won the most recent conflict, so fetch takes the next one
   logic last_d;
   always_ff @(posedge clk_i)
      if (rst_i) last_d <= 1'b1;
      else if (i_req && d_req) last_d <= d_win;
   assign i_win = i_req && (!d_req || last_d);
`else
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);
   logic [CW-1:0] starve_cnt;
   always_ff @(posedge clk_i)
      if (rst_i || !i_req || i_win) starve_cnt <= '0;
      else if (starve_cnt != CMAX) starve_cnt <= starve_cnt + 1'b1;
   assign i_win = i_req && (!d_req || starve_cnt == CMAX);
`endif
   assign d_win = d_req && !i_win;
endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-ported SRAM between fetch and LSU ports.
// Define RISCV_ARB_RR_EN for round-robin conflicts instead of fixed data priority.
module riscv_mem_arbiter
   import riscv_arb_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_req_i,
   input  logic [XLEN-1:0]   i_addr_i,
   output logic              i_gnt_o,
   output logic              i_rvalid_o,
   output logic [XLEN-1:0]   i_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [XLEN/8-1:0] d_be_i,
   input  logic [XLEN-1:0]   d_addr_i,
   input  logic [XLEN-1:0]   d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [XLEN-1:0]   d_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [XLEN/8-1:0] mem_be_o,
   output logic [XLEN-1:0]   mem_addr_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   input  logic [XLEN-1:0]   mem_rdata_i
);
   logic i_win, d_win;
   owner_t rd_owner;

   riscv_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .i_req(i_req_i),
      .d_req(d_req_i),
      .i_win(i_win),
      .d_win(d_win)
   );

   assign i_gnt_o     = !rst_i && i_win;
   assign d_gnt_o     = !rst_i && d_win;
   assign mem_req_o   = i_gnt_o || d_gnt_o;
   assign mem_we_o    = d_gnt_o && d_we_i;
   assign mem_be_o    = i_gnt_o ? '1 : d_be_i;
   assign mem_addr_o  = i_gnt_o ? i_addr_i : d_addr_i;
   assign mem_wdata_o = d_wdata_i;

   always_ff @(posedge clk_i)
      if (rst_i) rd_owner <= OWN_NONE;
      else rd_owner <= i_gnt_o ? OWN_INSTR : (d_gnt_o && !d_we_i) ? OWN_DATA : OWN_NONE;

   // gating with rst_i drops a read whose data would land during reset
   assign i_rvalid_o = !rst_i && rd_owner == OWN_INSTR;
   assign d_rvalid_o = !rst_i && rd_owner == OWN_DATA;
   assign i_rdata_o  = mem_rdata_i;
   assign d_rdata_o  = mem_rdata_i;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed + random checks of the arbiter against a behavioural model.
module tb_riscv_mem_arbiter;
   localparam int SM = 4;
   logic clk = 0, rst = 1;
   logic i_req = 0, d_req = 0, d_we = 0;
   logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
   logic [3:0] d_be = 0;
   logic i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [3:0] mem_be;

   always #5 clk = ~clk;

   riscv_mem_arbiter #(.XLEN(32), .STARVE_MAX(SM)) dut (
      .clk_i(clk), .rst_i(rst),
      .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt), .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   // synchronous SRAM with byte enables, one-cycle read latency
   logic [31:0] sram [256];
   logic [31:0] sram_q = 0;
   always @(posedge clk)
      if (mem_req) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else sram_q <= sram[mem_addr[9:2]];
      end
   assign mem_rdata = sram_q;

   int checks = 0, fails = 0;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
      end
   endtask

   // behavioural model: grant rules, reference memory and a one-deep pending-read record
   logic [31:0] ref_mem [256];
   int waited = 0;
   bit last_i = 0, pend_v = 0, pend_i = 0, ei, ed;
   logic [31:0] pend_d = 0;
   always @(negedge clk) begin
      if (rst) begin
         ei = 0; ed = 0;
      end else begin
`ifdef RISCV_ARB_RR_EN
         ei = i_req && (!d_req || !last_i);
`else
         ei = i_req && (!d_req || waited >= SM);
`endif
         ed = d_req && !ei;
      end
      chk("i_gnt", 32'(i_gnt), 32'(ei));
      chk("d_gnt", 32'(d_gnt), 32'(ed));
      chk("mem_req", 32'(mem_req), 32'(ei | ed));
      if (ei) begin
         chk("mem_addr_i", mem_addr, i_addr);
         chk("mem_we_i", 32'(mem_we), 0);
         chk("mem_be_i", 32'(mem_be), 32'hF);
      end
      if (ed) begin
         chk("mem_addr_d", mem_addr, d_addr);
         chk("mem_we_d", 32'(mem_we), 32'(d_we));
         chk("mem_be_d", 32'(mem_be), 32'(d_be));
         if (d_we) chk("mem_wdata", mem_wdata, d_wdata);
      end
      chk("i_rvalid", 32'(i_rvalid), 32'(!rst && pend_v && pend_i));
      chk("d_rvalid", 32'(d_rvalid), 32'(!rst && pend_v && !pend_i));
      if (!rst && pend_v) chk(pend_i ? "i_rdata" : "d_rdata", pend_i ? i_rdata : d_rdata, pend_d);
      if (rst) begin
         waited = 0; last_i = 0; pend_v = 0;
      end else begin
         waited = (i_req && !ei) ? waited + 1 : 0;
         if (i_req && d_req) last_i = ei;
         pend_v = ei || (ed && !d_we);
         pend_i = ei;
         pend_d = ref_mem[ei ? i_addr[9:2] : d_addr[9:2]];
         if (ed && d_we)
            for (int b = 0; b < 4; b++)
               if (d_be[b]) ref_mem[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
      end
   end

   task automatic cycle(input bit r, input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                        input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd);
      @(posedge clk);
      #1;
      rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_be = db; d_addr = da; d_wdata = dd;
      @(negedge clk);
      #1;
   endtask

   string exp_pat;
   bit ip = 0, dp = 0;
   logic [31:0] ra = 0, rda = 0, rdd = 0;
   bit rdw = 0;
   logic [3:0] rdb = 0;

   initial begin
      for (int k = 0; k < 256; k++) begin
         sram[k] = 32'hA500_0000 + k;
         ref_mem[k] = 32'hA500_0000 + k;
      end
      cycle(1, 1, 0, 1, 0, 4'hF, 0, 0);
      chk("rst_i_gnt", 32'(i_gnt), 0);
      chk("rst_d_gnt", 32'(d_gnt), 0);
      chk("rst_mem_req", 32'(mem_req), 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      // fetch stream
      cycle(0, 1, 32'h0, 0, 0, 0, 0, 0);
      chk("f0_gnt", 32'(i_gnt), 1);
      cycle(0, 1, 32'h4, 0, 0, 0, 0, 0);
      chk("f1_rvalid", 32'(i_rvalid), 1);
      chk("f1_rdata", i_rdata, 32'hA500_0000);
      cycle(0, 1, 32'h8, 0, 0, 0, 0, 0);
      chk("f2_rdata", i_rdata, 32'hA500_0001);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      chk("f3_rdata", i_rdata, 32'hA500_0002);
      chk("f3_d_rvalid", 32'(d_rvalid), 0);
      // partial write then read-back
      cycle(0, 0, 0, 1, 1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
      chk("w_gnt", 32'(d_gnt), 1);
      cycle(0, 0, 0, 1, 0, 4'hF, 32'h100, 0);
      chk("r_gnt", 32'(d_gnt), 1);
      chk("w_no_rvalid", 32'(d_rvalid), 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      chk("r_rvalid", 32'(d_rvalid), 1);
      chk("r_rdata", d_rdata, 32'hA500_BEEF);
      // continuous contention
`ifdef RISCV_ARB_RR_EN
      exp_pat = "IDIDIDIDID";
`else
      exp_pat = "DDDDIDDDDI";
`endif
      for (int k = 0; k < 10; k++) begin
         cycle(0, 1, 32'h20, 1, 0, 4'hF, 32'h40, 0);
         chk("pattern", 32'(i_gnt ? "I" : d_gnt ? "D" : "-"), 32'(exp_pat[k]));
      end
      cycle(0, 0, 0, 1, 0, 4'hF, 32'h44, 0);
      chk("lone_d_gnt", 32'(d_gnt), 1);
      // reset right after a granted data read
      cycle(0, 0, 0, 1, 0, 4'hF, 32'h48, 0);
      chk("pre_rst_gnt", 32'(d_gnt), 1);
      cycle(1, 1, 32'h4C, 1, 0, 4'hF, 32'h4C, 0);
      chk("rst_drop_rvalid", 32'(d_rvalid), 0);
      chk("rst_gnts", 32'({i_gnt, d_gnt, mem_req, i_rvalid}), 0);
      cycle(0, 1, 32'h4C, 0, 0, 0, 0, 0);
      chk("post_rst_gnt", 32'(i_gnt), 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      // random traffic, requests held until granted
      for (int k = 0; k < 400; k++) begin
         if (!ip && $urandom_range(1, 0) == 1) begin
            ip = 1; ra = 32'($urandom_range(15, 0)) << 2;
         end
         if (!dp && $urandom_range(2, 0) != 0) begin
            dp = 1; rda = 32'($urandom_range(15, 0)) << 2; rdw = $urandom_range(1, 0) == 1;
            rdb = 4'($urandom_range(15, 1)); rdd = $urandom;
         end
         cycle(0, ip, ra, dp, rdw, rdb, rda, rdd);
         if (i_gnt) ip = 0;
         if (d_gnt) dp = 0;
      end
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
